// File: rtl/ras_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : ras_sequencer_if
// Purpose  : Bundles the decode-offer handshake, branch-resolve inputs, the
//            registered return-address-stack command outputs and the status
//            outputs of ras_sequencer.
// Ports    : master = instruction/resolve source (drives in_*, resolve_*)
//            slave  = ras_sequencer (drives in_ready, ras_*, status, errors)
// Revision : 1.0 - initial release
// ============================================================================
interface ras_sequencer_if #(
   parameter int XLEN       = 32,
   parameter int STACK_SIZE = 16
);
   localparam int OCC_W = $clog2(STACK_SIZE) + 1;

   // Offer handshake
   logic             in_valid;
   logic             in_ready;
   logic             in_jump;
   logic             in_jump_type;
   logic             in_branch;
   logic [4:0]       in_rs1;
   logic [4:0]       in_rd;
   logic [XLEN-1:0]  in_return_addr;
   // Branch resolution
   logic             resolve_valid;
   logic             resolve_mispredict;
   // Registered stack commands
   logic             ras_push;
   logic             ras_pop;
   logic             ras_checkpoint;
   logic             ras_restore;
   logic [XLEN-1:0]  ras_address;
   // Status and sticky errors
   logic [1:0]       state;
   logic [OCC_W-1:0] occupancy;
   logic [7:0]       spec_jump_count;
   logic             overflow;
   logic             underflow;
   logic             protocol_error;

   modport master (
      output in_valid, in_jump, in_jump_type, in_branch, in_rs1, in_rd,
             in_return_addr, resolve_valid, resolve_mispredict,
      input  in_ready, ras_push, ras_pop, ras_checkpoint, ras_restore,
             ras_address, state, occupancy, spec_jump_count, overflow,
             underflow, protocol_error
   );

   modport slave (
      input  in_valid, in_jump, in_jump_type, in_branch, in_rs1, in_rd,
             in_return_addr, resolve_valid, resolve_mispredict,
      output in_ready, ras_push, ras_pop, ras_checkpoint, ras_restore,
             ras_address, state, occupancy, spec_jump_count, overflow,
             underflow, protocol_error
   );
endinterface
`default_nettype wire

// File: rtl/ras_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ras_sequencer
// Purpose  : Turns decoded JAL/JALR/branch offers into registered push/pop/
//            checkpoint/restore commands for a return address stack, tracks
//            stack depth, and restores that depth after a mispredicted branch.
// Ports    : clk   - clock, all state updates on rising edge
//            reset - synchronous active-high reset
//            bus   - ras_sequencer_if.slave (offer, resolve, commands, status)
// Revision : 1.0 - initial release
// ============================================================================
module ras_sequencer #(
   parameter int XLEN       = 32,
   parameter int STACK_SIZE = 16
) (
   input  wire logic        clk,
   input  wire logic        reset,
   ras_sequencer_if.slave   bus
);
   localparam int               OCC_W   = $clog2(STACK_SIZE) + 1;
   localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(STACK_SIZE);
   localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SPEC    = 2'd1,
      ST_RECOVER = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic [OCC_W-1:0]  saved_occ_q, saved_occ_d;
   logic [7:0]        jcnt_q, jcnt_d;
   logic              push_q, push_d;
   logic              pop_q, pop_d;
   logic              ckpt_q, ckpt_d;
   logic              restore_q, restore_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              perr_q, perr_d;

   logic in_ready;
   logic accept;
   logic rd_link, rs1_link;
   logic hint_push, hint_pop;
   logic take_jump;

   // x1/x5 are the link registers. A JALR that reads one link register and
   // writes the other is a return immediately followed by a call, so it both
   // pops and pushes; reading and writing the same link register is a call.
   assign rd_link   = (bus.in_rd  == 5'd1) || (bus.in_rd  == 5'd5);
   assign rs1_link  = (bus.in_rs1 == 5'd1) || (bus.in_rs1 == 5'd5);
   assign hint_push = bus.in_jump && rd_link;
   assign hint_pop  = bus.in_jump && bus.in_jump_type && rs1_link &&
                      (!rd_link || (bus.in_rd != bus.in_rs1));

   // A new branch cannot be speculated on top of a live checkpoint, and no
   // offer is taken in the cycle the checkpoint is resolved.
   always_comb begin
      in_ready = 1'b0;
      unique case (state_q)
         ST_IDLE:    in_ready = 1'b1;
         ST_SPEC:    in_ready = !bus.in_branch && !bus.resolve_valid;
         default:    in_ready = 1'b0;
      endcase
   end

   assign accept = bus.in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      occ_d       = occ_q;
      saved_occ_d = saved_occ_q;
      jcnt_d      = jcnt_q;
      push_d      = 1'b0;
      pop_d       = 1'b0;
      ckpt_d      = 1'b0;
      restore_d   = 1'b0;
      addr_d      = '0;
      ovf_d       = ovf_q;
      unf_d       = unf_q;
      perr_d      = perr_q;
      take_jump   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.resolve_valid) perr_d = 1'b1;
            if (accept) begin
               if (bus.in_branch) begin
                  // Branch wins over a simultaneous jump flag.
                  ckpt_d      = 1'b1;
                  state_d     = ST_SPEC;
                  saved_occ_d = occ_q;
                  jcnt_d      = '0;
                  if (bus.in_jump) perr_d = 1'b1;
               end else if (bus.in_jump) begin
                  take_jump = 1'b1;
               end
            end
         end
         ST_SPEC: begin
            if (bus.resolve_valid) begin
               if (bus.resolve_mispredict) begin
                  // Restore pulse is registered so it is visible for the
                  // single RECOVER cycle, alongside the rolled-back depth.
                  state_d   = ST_RECOVER;
                  restore_d = 1'b1;
                  occ_d     = saved_occ_q;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (accept && bus.in_jump) begin
               take_jump = 1'b1;
               if (jcnt_q != 8'hFF) jcnt_d = jcnt_q + 8'd1;
            end
         end
         ST_RECOVER: begin
            state_d = ST_IDLE;
            if (bus.resolve_valid) perr_d = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      if (take_jump) begin
         push_d = hint_push;
         pop_d  = hint_pop;
         addr_d = hint_push ? bus.in_return_addr : '0;
         // Commands are always issued; only the tracked depth saturates.
         if (hint_push && !hint_pop) begin
            if (occ_q == OCC_MAX) ovf_d = 1'b1;
            else                  occ_d = occ_q + OCC_ONE;
         end else if (hint_pop) begin
            if (occ_q == '0)      unf_d = 1'b1;
            else if (!hint_push)  occ_d = occ_q - OCC_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         occ_q       <= '0;
         saved_occ_q <= '0;
         jcnt_q      <= '0;
         push_q      <= 1'b0;
         pop_q       <= 1'b0;
         ckpt_q      <= 1'b0;
         restore_q   <= 1'b0;
         addr_q      <= '0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         perr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         occ_q       <= occ_d;
         saved_occ_q <= saved_occ_d;
         jcnt_q      <= jcnt_d;
         push_q      <= push_d;
         pop_q       <= pop_d;
         ckpt_q      <= ckpt_d;
         restore_q   <= restore_d;
         addr_q      <= addr_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
         perr_q      <= perr_d;
      end
   end

   assign bus.in_ready        = in_ready;
   assign bus.ras_push        = push_q;
   assign bus.ras_pop         = pop_q;
   assign bus.ras_checkpoint  = ckpt_q;
   assign bus.ras_restore     = restore_q;
   assign bus.ras_address     = addr_q;
   assign bus.state           = state_q;
   assign bus.occupancy       = occ_q;
   assign bus.spec_jump_count = jcnt_q;
   assign bus.overflow        = ovf_q;
   assign bus.underflow       = unf_q;
   assign bus.protocol_error  = perr_q;
endmodule
`default_nettype wire

// File: tb/tb_ras_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ras_sequencer
// Purpose  : Self-checking bench for ras_sequencer. Each vector drives one
//            cycle of inputs, checks the combinational in_ready, queues its
//            expected registered outputs and compares them after the edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ras_sequencer;
   localparam int XLEN       = 32;
   localparam int STACK_SIZE = 16;

   typedef struct {
      logic [4:0]  ctl;   // reset, in_valid, in_jump, in_jump_type, in_branch
      logic [4:0]  rs1;
      logic [4:0]  rd;
      logic [31:0] ra;
      logic [1:0]  res;   // resolve_valid, resolve_mispredict
      logic [4:0]  cmd;   // in_ready, push, pop, checkpoint, restore
      logic [31:0] addr;
      logic [1:0]  st;
      logic [4:0]  occ;
      logic [7:0]  cnt;
      logic [2:0]  err;   // overflow, underflow, protocol_error
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   vec_t sb_q[$];
   vec_t tbl[30];

   ras_sequencer_if #(.XLEN(XLEN), .STACK_SIZE(STACK_SIZE)) bus ();

   ras_sequencer #(.XLEN(XLEN), .STACK_SIZE(STACK_SIZE)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog_timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s vec=%0d got=%0h expected=%0h", nm, id, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int id);
      vec_t e;
      rst                    = v.ctl[4];
      bus.in_valid           = v.ctl[3];
      bus.in_jump            = v.ctl[2];
      bus.in_jump_type       = v.ctl[1];
      bus.in_branch          = v.ctl[0];
      bus.in_rs1             = v.rs1;
      bus.in_rd              = v.rd;
      bus.in_return_addr     = v.ra;
      bus.resolve_valid      = v.res[1];
      bus.resolve_mispredict = v.res[0];
      #1;
      chk("in_ready", id, 32'(bus.in_ready), 32'(v.cmd[4]));
      sb_q.push_back(v);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_empty vec=%0d got=0 expected=1", id);
      end else begin
         e = sb_q.pop_front();
         chk("ras_cmd", id, 32'({bus.ras_push, bus.ras_pop, bus.ras_checkpoint, bus.ras_restore}), 32'(e.cmd[3:0]));
         chk("ras_address", id, bus.ras_address, e.addr);
         chk("state", id, 32'(bus.state), 32'(e.st));
         chk("occupancy", id, 32'(bus.occupancy), 32'(e.occ));
         chk("spec_jump_count", id, 32'(bus.spec_jump_count), 32'(e.cnt));
         chk("errors", id, 32'({bus.overflow, bus.underflow, bus.protocol_error}), 32'(e.err));
      end
   endtask

   function automatic vec_t jump_vec(input logic jalr, input logic [4:0] rs1, input logic [4:0] rd, input logic [31:0] ra);
      vec_t v;
      v.ctl  = {2'b01, 1'b1, jalr, 1'b0};
      v.rs1  = rs1;
      v.rd   = rd;
      v.ra   = ra;
      v.res  = 2'b00;
      v.cmd  = 5'b10000;
      v.addr = '0;
      v.st   = 2'd0;
      v.occ  = '0;
      v.cnt  = '0;
      v.err  = '0;
      return v;
   endfunction

   initial begin
      vec_t v;
      checks   = 0;
      failures = 0;

      //          ctl       rs1   rd    ra         res    cmd       addr       st    occ   cnt   err
      tbl[0]  = '{5'b01100, 5'd0, 5'd1, 32'h104,   2'b00, 5'b11000, 32'h104,   2'd0, 5'd1, 8'd0, 3'b000};
      tbl[1]  = '{5'b01100, 5'd0, 5'd5, 32'h200,   2'b00, 5'b11000, 32'h200,   2'd0, 5'd2, 8'd0, 3'b000};
      tbl[2]  = '{5'b01110, 5'd1, 5'd5, 32'h300,   2'b00, 5'b11100, 32'h300,   2'd0, 5'd2, 8'd0, 3'b000};
      tbl[3]  = '{5'b01110, 5'd1, 5'd0, 32'h304,   2'b00, 5'b10100, 32'h0,     2'd0, 5'd1, 8'd0, 3'b000};
      tbl[4]  = '{5'b01110, 5'd5, 5'd0, 32'h308,   2'b00, 5'b10100, 32'h0,     2'd0, 5'd0, 8'd0, 3'b000};
      tbl[5]  = '{5'b01110, 5'd1, 5'd1, 32'h400,   2'b00, 5'b11000, 32'h400,   2'd0, 5'd1, 8'd0, 3'b000};
      tbl[6]  = '{5'b01100, 5'd0, 5'd0, 32'h404,   2'b00, 5'b10000, 32'h0,     2'd0, 5'd1, 8'd0, 3'b000};
      tbl[7]  = '{5'b01110, 5'd6, 5'd0, 32'h408,   2'b00, 5'b10000, 32'h0,     2'd0, 5'd1, 8'd0, 3'b000};
      tbl[8]  = '{5'b00100, 5'd0, 5'd1, 32'h40c,   2'b00, 5'b10000, 32'h0,     2'd0, 5'd1, 8'd0, 3'b000};
      tbl[9]  = '{5'b01100, 5'd0, 5'd1, 32'h500,   2'b00, 5'b11000, 32'h500,   2'd0, 5'd2, 8'd0, 3'b000};
      tbl[10] = '{5'b01001, 5'd0, 5'd0, 32'h0,     2'b00, 5'b10010, 32'h0,     2'd1, 5'd2, 8'd0, 3'b000};
      tbl[11] = '{5'b01100, 5'd0, 5'd1, 32'h600,   2'b00, 5'b11000, 32'h600,   2'd1, 5'd3, 8'd1, 3'b000};
      tbl[12] = '{5'b01100, 5'd0, 5'd1, 32'h700,   2'b00, 5'b11000, 32'h700,   2'd1, 5'd4, 8'd2, 3'b000};
      tbl[13] = '{5'b00000, 5'd0, 5'd0, 32'h0,     2'b11, 5'b00001, 32'h0,     2'd2, 5'd2, 8'd2, 3'b000};
      tbl[14] = '{5'b01100, 5'd0, 5'd1, 32'h800,   2'b00, 5'b00000, 32'h0,     2'd0, 5'd2, 8'd2, 3'b000};
      tbl[15] = '{5'b01001, 5'd0, 5'd0, 32'h0,     2'b00, 5'b10010, 32'h0,     2'd1, 5'd2, 8'd0, 3'b000};
      tbl[16] = '{5'b01001, 5'd0, 5'd0, 32'h0,     2'b00, 5'b00000, 32'h0,     2'd1, 5'd2, 8'd0, 3'b000};
      tbl[17] = '{5'b01001, 5'd0, 5'd0, 32'h0,     2'b10, 5'b00000, 32'h0,     2'd0, 5'd2, 8'd0, 3'b000};
      tbl[18] = '{5'b01001, 5'd0, 5'd0, 32'h0,     2'b00, 5'b10010, 32'h0,     2'd1, 5'd2, 8'd0, 3'b000};
      tbl[19] = '{5'b01110, 5'd1, 5'd5, 32'h900,   2'b00, 5'b11100, 32'h900,   2'd1, 5'd2, 8'd1, 3'b000};
      tbl[20] = '{5'b00000, 5'd0, 5'd0, 32'h0,     2'b11, 5'b00001, 32'h0,     2'd2, 5'd2, 8'd1, 3'b000};
      tbl[21] = '{5'b00000, 5'd0, 5'd0, 32'h0,     2'b00, 5'b00000, 32'h0,     2'd0, 5'd2, 8'd1, 3'b000};
      tbl[22] = '{5'b01001, 5'd0, 5'd0, 32'h0,     2'b00, 5'b10010, 32'h0,     2'd1, 5'd2, 8'd0, 3'b000};
      tbl[23] = '{5'b10000, 5'd0, 5'd0, 32'h0,     2'b11, 5'b00000, 32'h0,     2'd0, 5'd0, 8'd0, 3'b000};
      tbl[24] = '{5'b01101, 5'd0, 5'd1, 32'ha00,   2'b00, 5'b10010, 32'h0,     2'd1, 5'd0, 8'd0, 3'b001};
      tbl[25] = '{5'b01100, 5'd0, 5'd1, 32'ha04,   2'b00, 5'b11000, 32'ha04,   2'd1, 5'd1, 8'd1, 3'b001};
      tbl[26] = '{5'b00000, 5'd0, 5'd0, 32'h0,     2'b11, 5'b00001, 32'h0,     2'd2, 5'd0, 8'd1, 3'b001};
      tbl[27] = '{5'b11100, 5'd0, 5'd1, 32'ha08,   2'b00, 5'b00000, 32'h0,     2'd0, 5'd0, 8'd0, 3'b000};
      tbl[28] = '{5'b01100, 5'd0, 5'd1, 32'hb00,   2'b10, 5'b11000, 32'hb00,   2'd0, 5'd1, 8'd0, 3'b001};
      tbl[29] = '{5'b10000, 5'd0, 5'd0, 32'h0,     2'b00, 5'b10000, 32'h0,     2'd0, 5'd0, 8'd0, 3'b000};

      // Reset state
      rst                    = 1'b1;
      bus.in_valid           = 1'b0;
      bus.in_jump            = 1'b0;
      bus.in_jump_type       = 1'b0;
      bus.in_branch          = 1'b0;
      bus.in_rs1             = '0;
      bus.in_rd              = '0;
      bus.in_return_addr     = '0;
      bus.resolve_valid      = 1'b0;
      bus.resolve_mispredict = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", -1, 32'(bus.state), 32'd0);
      chk("reset_occupancy", -1, 32'(bus.occupancy), 32'd0);
      chk("reset_cmd", -1, 32'({bus.ras_push, bus.ras_pop, bus.ras_checkpoint, bus.ras_restore}), 32'd0);
      chk("reset_address", -1, bus.ras_address, 32'd0);
      chk("reset_count", -1, 32'(bus.spec_jump_count), 32'd0);
      chk("reset_errors", -1, 32'({bus.overflow, bus.underflow, bus.protocol_error}), 32'd0);

      for (int i = 0; i < 30; i++) run_vec(tbl[i], i);

      // Fill past capacity: commands keep coming, depth saturates at 16.
      for (int k = 1; k <= STACK_SIZE + 1; k++) begin
         v      = jump_vec(1'b0, 5'd0, 5'd1, 32'h1000 + 32'(k * 4));
         v.cmd  = 5'b11000;
         v.addr = v.ra;
         v.occ  = (k > STACK_SIZE) ? 5'(STACK_SIZE) : 5'(k);
         v.err  = (k > STACK_SIZE) ? 3'b100 : 3'b000;
         run_vec(v, 100 + k);
      end

      // Drain back to empty, then pop once more at empty.
      for (int k = 1; k <= STACK_SIZE + 1; k++) begin
         v     = jump_vec(1'b1, 5'd1, 5'd0, 32'h2000);
         v.cmd = 5'b10100;
         v.occ = (k > STACK_SIZE) ? 5'd0 : 5'(STACK_SIZE - k);
         v.err = (k > STACK_SIZE) ? 3'b110 : 3'b100;
         run_vec(v, 200 + k);
      end

      // Pop+push at empty: both commands issued, depth stays 0.
      v      = jump_vec(1'b1, 5'd5, 5'd1, 32'hc00);
      v.cmd  = 5'b11100;
      v.addr = 32'hc00;
      v.err  = 3'b110;
      run_vec(v, 300);

      if (sb_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_leftover got=%0d expected=0", sb_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
